vector_recorder: RTL and testbench

Hardware counterpart of our file-driven vector benches: rather than replaying stored vectors into a DUT, this block generates them. It exhaustively sweeps every input combination of a small combinational DUT, captures the DUT response for each, and stores `{inputs, output}` words in the same packing as our `.tv` vector files. It then streams the stored vectors out over a valid/ready port for dumping or cross-checking.

---
 rtl/vec_pkg.sv | 16 +
 rtl/vector_recorder_if.sv | 15 +
 rtl/vec_mem.sv | 26 ++
 rtl/vector_recorder.sv | 112 +++++++++++
 tb/tb_vector_recorder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared types for the vector recorder: FSM state encoding and vector word sizing.
package vec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } vr_state_t;

    // One vector word holds every input bit plus the single DUT response bit.
    function automatic int vec_word_width(input int nin);
        return nin + 1;
    endfunction

endpackage

// File: rtl/vector_recorder_if.sv
// Valid/ready read stream carrying recorded {stim, resp} vector words.
interface vector_recorder_if #(
    parameter int NIN = 3
);
    localparam int W = vec_pkg::vec_word_width(NIN);

    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;
    logic         rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);

endinterface

// File: rtl/vec_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
module vec_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 4,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage and read register take no reset so this maps onto block RAM;
    // the top masks rdata whenever it is not valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vector_recorder.sv
// Sweeps all NIN-bit stimuli into a combinational DUT, records {stim, resp}, then streams them out.
module vector_recorder
    import vec_pkg::*;
#(
    parameter int NIN = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [NIN-1:0]           stim,
    input  logic                     resp,
    output logic                     busy,
    output logic                     done,
    vector_recorder_if.master        rd
);

    localparam int W     = vec_word_width(NIN);
    localparam int DEPTH = 1 << NIN;
    localparam int CW    = NIN + 1;

    vr_state_t      state, state_nxt;
    logic [CW-1:0]  k, k_nxt, k_inc;
    logic [CW-1:0]  ptr, ptr_nxt, ptr_inc;
    logic [NIN-1:0] raddr;
    logic [W-1:0]   mem_q;
    logic           we;
    logic           xfer;
    logic           last;

    assign k_inc   = k + CW'(1);
    assign ptr_inc = ptr + CW'(1);
    assign last    = (state == DUMP) && (ptr == CW'(DEPTH - 1));
    assign xfer    = (state == DUMP) && rd.rd_ready;

    // NOTE: every output of this block is given a default first, so no branch
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        ptr_nxt   = ptr;
        we        = 1'b0;
        raddr     = ptr[NIN-1:0];
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                    k_nxt     = '0;
                end
            end
            SWEEP: begin
                we    = 1'b1;
                k_nxt = k_inc;
                if (k_inc == CW'(DEPTH)) begin
                    state_nxt = DUMP;
                    k_nxt     = '0;
                    ptr_nxt   = '0;
                end
            end
            DUMP: begin
                // Prefetch: address the word that will be presented next cycle.
                if (xfer) begin
                    ptr_nxt = last ? '0 : ptr_inc;
                    raddr   = ptr_nxt[NIN-1:0];
                    if (last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            k     <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            ptr   <= ptr_nxt;
        end
    end

    vec_mem #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (NIN)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (k[NIN-1:0]),
        .wdata ({k[NIN-1:0], resp}),
        .raddr (raddr),
        .rdata (mem_q)
    );

    // k is cleared on every exit from SWEEP, so stim reads 0 outside the sweep.
    assign stim        = k[NIN-1:0];
    assign busy        = (state == SWEEP) || (state == DUMP);
    assign done        = (state == DONE);
    assign rd.rd_valid = (state == DUMP);
    assign rd.rd_last  = last;
    assign rd.rd_data  = (state == DUMP) ? mem_q : '0;

endmodule

// File: tb/tb_vector_recorder.sv
// Scoreboard bench: NIN=3 recorder on y = ~b & (~c | a), plus NIN=1 recorder on y = ~a.
module tb_vector_recorder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: NIN=3
    logic       start0 = 1'b0;
    logic [2:0] stim0;
    logic       resp0, busy0, done0;
    vector_recorder_if #(.NIN(3)) rd0 ();
    assign resp0 = ~stim0[1] & (~stim0[0] | stim0[2]);

    vector_recorder #(.NIN(3)) dut0 (
        .clk   (clk),
        .reset (reset),
        .start (start0),
        .stim  (stim0),
        .resp  (resp0),
        .busy  (busy0),
        .done  (done0),
        .rd    (rd0)
    );

    // Instance 1: NIN=1
    logic       start1 = 1'b0;
    logic [0:0] stim1;
    logic       resp1, busy1, done1;
    vector_recorder_if #(.NIN(1)) rd1 ();
    assign resp1 = ~stim1[0];

    vector_recorder #(.NIN(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .stim  (stim1),
        .resp  (resp1),
        .busy  (busy1),
        .done  (done1),
        .rd    (rd1)
    );

    int checks = 0;
    int errors = 0;

    // Expected words with rd_last appended as bit 0.
    logic [4:0] q0 [$];
    logic [2:0] q1 [$];
    int         xfer0 = 0;

    logic [3:0] words3 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0110,
                               4'b1001, 4'b1011, 4'b1100, 4'b1110};
    logic [3:0] bp_pat = 4'b1001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor instance 0: pop and compare on every accepted word; check hold under backpressure.
    logic       hold0 = 1'b0;
    logic [3:0] prev0;
    always @(negedge clk) begin
        if (reset && rd0.rd_valid) begin
            if (hold0) check("hold_stable", rd0.rd_data, prev0);
            if (rd0.rd_ready) begin
                if (q0.size() == 0) begin
                    fail("unexpected_word0");
                end else begin
                    logic [4:0] e;
                    e = q0.pop_front();
                    check("rd_data0", rd0.rd_data, e[4:1]);
                    check("rd_last0", rd0.rd_last, e[0]);
                    xfer0++;
                end
            end
            hold0 = !rd0.rd_ready;
            prev0 = rd0.rd_data;
        end else begin
            hold0 = 1'b0;
        end
    end

    // Monitor instance 1.
    always @(negedge clk) begin
        if (reset && rd1.rd_valid && rd1.rd_ready) begin
            if (q1.size() == 0) begin
                fail("unexpected_word1");
            end else begin
                logic [2:0] e;
                e = q1.pop_front();
                check("rd_data1", rd1.rd_data, e[2:1]);
                check("rd_last1", rd1.rd_last, e[0]);
            end
        end
    end

    task automatic push_all0(input int n);
        for (int i = 0; i < n; i++) q0.push_back({words3[i], i == 7});
    endtask

    // Full run on instance 0: start, optional backpressure / start pokes, wait for done.
    task automatic run0(input string tag, input int exp_lat, input bit bp, input bit poke);
        int  cnt;
        bit  seen;
        push_all0(8);
        cnt    = 0;
        seen   = 1'b0;
        start0 = 1'b1;
        while (!seen && cnt < 300) begin
            tick();
            cnt++;
            start0 = poke && (cnt == 3 || cnt == 11);
            if (bp) rd0.rd_ready = bp_pat[cnt % 4];
            if (cnt >= 1 && cnt <= 8) check({tag, "_sweep_stim"}, stim0, cnt - 1);
            if (cnt == 9) begin
                check({tag, "_first_valid"}, rd0.rd_valid, 1);
                check({tag, "_stim_after"}, stim0, 0);
            end
            seen = done0;
        end
        if (!seen) fail({tag, "_done_timeout"});
        else if (exp_lat > 0) check({tag, "_latency"}, cnt, exp_lat);
        start0 = poke;
        tick();
        start0 = 1'b0;
        check({tag, "_done_pulse"}, done0, 0);
        check({tag, "_idle_busy"}, busy0, 0);
        rd0.rd_ready = 1'b1;
        check({tag, "_drained"}, q0.size(), 0);
    endtask

    initial begin
        int cnt;
        bit seen;
        rd0.rd_ready = 1'b1;
        rd1.rd_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_stim", stim0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_valid", rd0.rd_valid, 0);
        check("rst_last", rd0.rd_last, 0);
        check("rst_data", rd0.rd_data, 0);
        check("rst_busy1", busy1, 0);
        reset = 1'b1;
        tick();

        run0("basic", 17, 1'b0, 1'b0);
        run0("bp", 0, 1'b1, 1'b0);
        run0("poke", 17, 1'b0, 1'b1);

        // Reset mid-sweep at k=4
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        check("mid_sweep_k", stim0, 4);
        reset = 1'b0;
        tick();
        check("rst_sweep_stim", stim0, 0);
        check("rst_sweep_busy", busy0, 0);
        check("rst_sweep_valid", rd0.rd_valid, 0);
        reset = 1'b1;
        tick();
        run0("after_sweep_rst", 17, 1'b0, 1'b0);

        // Reset mid-dump after 3 transfers
        push_all0(3);
        xfer0  = 0;
        cnt    = 0;
        start0 = 1'b1;
        while (xfer0 < 3 && cnt < 100) begin
            tick();
            cnt++;
            start0 = 1'b0;
        end
        if (xfer0 < 3) fail("dump_xfer_timeout");
        reset = 1'b0;
        tick();
        check("rst_dump_valid", rd0.rd_valid, 0);
        check("rst_dump_busy", busy0, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= done0;
            if (i == 1) reset = 1'b1;
            tick();
        end
        check("rst_dump_no_done", seen, 0);
        check("rst_dump_count", q0.size(), 0);
        run0("after_dump_rst", 17, 1'b0, 1'b0);

        // NIN=1 instance
        q1.push_back(3'b010);
        q1.push_back(3'b101);
        cnt    = 0;
        seen   = 1'b0;
        start1 = 1'b1;
        while (!seen && cnt < 50) begin
            tick();
            cnt++;
            start1 = 1'b0;
            seen   = done1;
        end
        if (!seen) fail("nin1_done_timeout");
        else check("nin1_latency", cnt, 5);
        tick();
        check("nin1_drained", q1.size(), 0);
        check("nin1_idle", busy1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
